// File: rtl/vpu_pkg.sv
// Shared types for the VPU command sequencer: geometry opcodes, the queued
// command record and the issue FSM states.
package vpu_pkg;

  typedef enum logic [3:0] {
    OP_CRT  = 4'd0,
    OP_DEL  = 4'd1,
    OP_XL1  = 4'd3,
    OP_XL   = 4'd4,
    OP_SCL  = 4'd5,
    OP_ROTL = 4'd6,
    OP_ROTR = 4'd7
  } gmt_op_e;

  // op is kept as raw bits so undefined opcodes pass through untouched.
  typedef struct packed {
    logic [3:0]   op;
    logic [3:0]   code;
    logic [4:0]   obj_num;
    logic [1:0]   obj_type;
    logic [7:0]   obj_color;
    logic [127:0] v;
  } vpu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO
  } seq_state_t;

endpackage

// File: rtl/vpu_cmd_fifo.sv
// Synchronous FIFO of vpu_cmd_t with full/empty flags and occupancy count.
// DEPTH must be a power of two so the pointers wrap by overflow.
module vpu_cmd_fifo
  import vpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  vpu_cmd_t                 i_wdata,
  input  logic                     i_pop,
  output vpu_cmd_t                 o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  vpu_cmd_t         r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; r_count guarantees stale entries are never consumed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vpu_cmd_sequencer.sv
// Queues CPU geometry commands and hands them one at a time to matrix_unit,
// holding operands steady until matrix_unit's busy handshake completes.
module vpu_cmd_sequencer
  import vpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic [3:0]             cmd_code,
  input  logic [4:0]             cmd_obj_num,
  input  logic [1:0]             cmd_obj_type,
  input  logic [7:0]             cmd_obj_color,
  input  logic [127:0]           cmd_v,
  output logic                   mat_go,
  output logic [3:0]             mat_op,
  output logic [3:0]             mat_code,
  output logic [4:0]             mat_obj_num,
  output logic [1:0]             mat_obj_type,
  output logic [7:0]             mat_obj_color,
  output logic [127:0]           mat_v,
  input  logic                   mat_busy,
  input  logic                   obj_mem_full,
  input  logic                   clip_reading,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   idle,
  output logic                   cmd_done,
  output logic                   cmd_rej,
  output logic                   timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  seq_state_t       r_state;
  vpu_cmd_t         r_opnd;
  logic [TW-1:0]    r_timer;
  vpu_cmd_t         w_wdata;
  vpu_cmd_t         w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_wdata = '{op: cmd_op, code: cmd_code, obj_num: cmd_obj_num,
                     obj_type: cmd_obj_type, obj_color: cmd_obj_color, v: cmd_v};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  // The head is only taken when matrix_unit is free and the clipper is off the bus.
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && !clip_reading && !mat_busy;
  assign idle      = (r_state == ST_IDLE) && (q_count == '0);

  assign mat_op        = r_opnd.op;
  assign mat_code      = r_opnd.code;
  assign mat_obj_num   = r_opnd.obj_num;
  assign mat_obj_type  = r_opnd.obj_type;
  assign mat_obj_color = r_opnd.obj_color;
  assign mat_v         = r_opnd.v;

  vpu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (q_count)
  );

  // NOTE: all state and pulse outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_opnd      <= '0;
      r_timer     <= '0;
      mat_go      <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_rej     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mat_go   <= 1'b0;
      cmd_done <= 1'b0;
      cmd_rej  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_opnd <= w_head;
            if (w_head.op == 4'(OP_CRT) && obj_mem_full) begin
              cmd_rej <= 1'b1;
            end else begin
              mat_go  <= 1'b1;
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          r_timer <= '0;
          r_state <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (mat_busy) begin
            r_state <= ST_WAIT_LO;
          end else if (r_timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            cmd_done    <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_LO: begin
          if (!mat_busy) begin
            cmd_done <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/vpu_cmd_sequencer.md
Name: vpu_cmd_sequencer

Overview:
- Buffers CPU geometry commands (create, delete, translate, translate-one, scale, rotate) in a small FIFO.
- Issues each command to matrix_unit as a one-cycle go pulse, holding operands stable until matrix_unit busy completes.
- Defers issue while the clipping unit is reading video memory; rejects creates when object memory is full.
- Sits between the CPU register interface and matrix_unit, so the CPU no longer polls busy per command.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- BUSY_TIMEOUT, 16, cycles to wait for mat_busy to rise after go before flagging a timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  CPU command present
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_op  in  4  gmt_op (0 crt, 1 del, 3 xlate-one, 4 xlate, 5 scale, 6 rotl, 7 rotr)
- cmd_code  in  4  gmt_code
- cmd_obj_num  in  5  target object
- cmd_obj_type  in  2  type for create
- cmd_obj_color  in  8  colour for create
- cmd_v  in  128  v0..v7 packed, v0 in [15:0]
- mat_go  out  1  one-cycle start to matrix_unit
- mat_op, mat_code, mat_obj_num, mat_obj_type, mat_obj_color, mat_v  out  4/4/5/2/8/128  operands to matrix_unit
- mat_busy  in  1  matrix_unit busy
- obj_mem_full  in  1  object memory full
- clip_reading  in  1  clipper reading video memory
- q_count  out  $clog2(DEPTH)+1  occupancy
- idle  out  1  FIFO empty and FSM in IDLE
- cmd_done  out  1  one-cycle pulse per completed command
- cmd_rej  out  1  one-cycle pulse when a create is dropped because memory is full
- timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset values:
  - mat_go=0, all mat_* operands=0, q_count=0, cmd_ready=1, idle=1, cmd_done=0, cmd_rej=0, timeout_err=0.
  - FIFO pointers cleared; FSM in IDLE.
  - Reset mid-command abandons it; matrix_unit is reset by the same domain.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - Pop occurs when the head is taken in IDLE.
  - Simultaneous push and pop when full is not possible, because cmd_ready=0 when full.
  - Simultaneous push and pop otherwise leaves q_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
  - IDLE: if FIFO is non-empty, !clip_reading and !mat_busy:
    - pop the head into the operand register.
    - If op==0 and obj_mem_full: pulse cmd_rej, stay in IDLE, no go.
    - Otherwise go to ISSUE.
  - ISSUE: mat_go=1 for exactly this cycle → WAIT_HI, timer cleared.
  - WAIT_HI:
    - If mat_busy=1 → WAIT_LO.
    - Otherwise the timer increments; at timer==BUSY_TIMEOUT-1, set timeout_err, pulse cmd_done → IDLE.
  - WAIT_LO: when mat_busy=0 → pulse cmd_done, → IDLE.
- Operand registers hold their value from the pop until the next pop; they never change while in ISSUE/WAIT_*.
- Latency: push into an empty FIFO in cycle N (idle, clip_reading=0) → mat_go high in cycle N+2 (N+1 pop into operand register, N+2 ISSUE). Next pop no earlier than the cycle after cmd_done.
- clip_reading rising during WAIT_* has no effect on the command in flight; it only gates the next pop.
- Invalid ops (2, 8–15) are passed through unchanged; matrix_unit defines their handling.
- idle = (state==IDLE)&&(q_count==0).

Decomposition:
- Package vpu_pkg holds:
  - the gmt_op enum (OP_CRT=0, OP_DEL=1, OP_XL1=3, OP_XL=4, OP_SCL=5, OP_ROTL=6, OP_ROTR=7);
  - a packed struct vpu_cmd_t {op, code, obj_num, obj_type, obj_color, v[127:0]} (151 bits);
  - the seq_state_t enum.
- One sub-module, vpu_cmd_fifo: a parameterised synchronous FIFO of vpu_cmd_t with full/empty/count.

Test Plan:
- Single translate (op=4, obj=1, v0=300, code=2) into an empty FIFO; model busy high 1 cycle after go for 10 cycles → mat_go at N+2 for one cycle, mat_v[15:0]=300 stable, cmd_done one cycle after busy falls, idle=1.
- Push 4 commands back-to-back with busy held high → cmd_ready=0 after the 4th, q_count=4 (≤1 popped while blocked). Release → commands issue in order, four cmd_done pulses, q_count returns to 0.
- obj_mem_full=1, push create (op=0, type=3) → cmd_rej pulse, no mat_go, no cmd_done. A following delete (op=1, obj=2) issues normally.
- clip_reading=1 held 20 cycles with 2 queued → no mat_go during the window; first go 2 cycles after clip_reading falls.
- Busy never rises with BUSY_TIMEOUT=16 → timeout_err set at cycle 16 of WAIT_HI, cmd_done pulses, next command proceeds, timeout_err stays 1.
- rst asserted during WAIT_LO with 3 queued → next cycle: q_count=0, idle=1, mat_go=0, mat_* operands=0.
